// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared widths and FSM state encoding for mem_responder
package mem_responder_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;
endpackage

// File: rtl/mem_responder_mem_array.sv
// mem_array: word storage with synchronous write and a registered, resettable read port
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_W-1:0]    wdata,
  output logic [DATA_W-1:0]    rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_BITS];
  // storage is deliberately left out of reset so contents survive it
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
  // read register clears on reset and otherwise holds until the next read
  always_ff @(posedge clk or posedge reset)
    if (reset) rdata <= '0;
    else if (re) rdata <= mem[addr];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: wait-state memory slave (IDLE -> WAIT -> ACCESS); optional MEM_RESPONDER_RANGE_CHECK_EN adds err
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_BITS   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic              read_sel,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              busy
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
  ,
  output logic              err
`endif
);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  state_t state, state_n;
  logic [3:0] cnt;
  logic [ADDR_W-1:0] addr_q;
  logic we_q;
  logic [DATA_W-1:0] wdata_q, mem_q;
  logic oob, mem_we, mem_re;
  wire start = state == IDLE && req;
  // state and wait counter; reset aborts any transaction in flight
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= start ? WAIT_INIT : state == WAIT ? cnt - 4'd1 : cnt;
    end
  // capture the request so later input changes cannot disturb it
  always_ff @(posedge clk)
    if (start) begin
      addr_q  <= read_sel ? alu_addr : pc_addr;
      we_q    <= we;
      wdata_q <= wdata;
    end
  // next state, completion strobe and memory controls
  always_comb begin
    state_n = state == IDLE ? (req ? (WAIT_CYCLES == 0 ? ACCESS : WAIT) : IDLE)
            : state == WAIT ? (cnt == 4'd1 ? ACCESS : WAIT)
            : IDLE;
    ack    = state == ACCESS;
    busy   = state != IDLE;
    mem_we = ack && we_q && !oob;
    mem_re = ack && !we_q;
  end
  mem_array #(.ADDR_BITS(ADDR_BITS)) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (ADDR_BITS'(addr_q)),
    .wdata (wdata_q),
    .rdata (mem_q)
  );
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
  logic rd_oob;
  assign oob = (addr_q >> ADDR_BITS) != '0;
  assign err = ack && oob;
  // remembers whether the last completed read was out of range
  always_ff @(posedge clk or posedge reset)
    if (reset) rd_oob <= 1'b0;
    else if (mem_re) rd_oob <= oob;
  assign rdata = rd_oob ? '1 : mem_q;
`else
  assign oob   = 1'b0;
  assign rdata = mem_q;
`endif
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of mem_responder with WAIT_CYCLES 2 and 0 (MEM_RESPONDER_RANGE_CHECK_EN aware)
module tb_mem_responder;
  logic clk = 0, reset;
  logic req0, req1, we, read_sel;
  logic [15:0] pc_addr, alu_addr, wdata, rdata0, rdata1;
  logic ack0, busy0, ack1, busy1;
  logic err0, err1;
  int checks = 0, errors = 0;
  int lat, bc, a1, a2, idle, acks;
  logic e;
  logic [15:0] r1;

  always #5 clk = ~clk;

  mem_responder #(.WAIT_CYCLES(2), .ADDR_BITS(8)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we), .read_sel(read_sel),
    .pc_addr(pc_addr), .alu_addr(alu_addr), .wdata(wdata),
    .rdata(rdata0), .ack(ack0), .busy(busy0)
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
    , .err(err0)
`endif
  );

  mem_responder #(.WAIT_CYCLES(0), .ADDR_BITS(8)) dut1 (
    .clk(clk), .reset(reset), .req(req1), .we(we), .read_sel(read_sel),
    .pc_addr(pc_addr), .alu_addr(alu_addr), .wdata(wdata),
    .rdata(rdata1), .ack(ack1), .busy(busy1)
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
    , .err(err1)
`endif
  );

`ifndef MEM_RESPONDER_RANGE_CHECK_EN
  assign err0 = 1'b0;
  assign err1 = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one transaction on dut<which>; inputs are scrambled after the latch edge
  task automatic xact(input int which, input logic w, input logic sel, input logic [15:0] addr,
                      input logic [15:0] d, output int l, output int b, output logic ev);
    @(negedge clk);
    we = w;
    read_sel = sel;
    pc_addr = sel ? 16'h00AA : addr;
    alu_addr = sel ? addr : 16'h00AA;
    wdata = d;
    if (which == 0) req0 = 1; else req1 = 1;
    l = 0;
    b = 0;
    ev = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (which == 0 ? busy0 : busy1) b++;
      if (which == 0 ? ack0 : ack1) begin
        l = n;
        ev = which == 0 ? err0 : err1;
        break;
      end
      if (n == 1) begin
        we = ~w;
        pc_addr = 16'h0003;
        alu_addr = 16'h0003;
        wdata = 16'hDEAD;
      end
    end
    req0 = 0;
    req1 = 0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1; req0 = 0; req1 = 0; we = 0; read_sel = 0;
    pc_addr = 0; alu_addr = 0; wdata = 0;
    repeat (3) @(negedge clk);
    check("rst_rdata0", rdata0, 0);
    check("rst_ack0", ack0, 0);
    check("rst_busy0", busy0, 0);
    check("rst_rdata1", rdata1, 0);
    reset = 0;
    xact(0, 1, 1, 16'h0005, 16'h1234, lat, bc, e);
    check("wr_latency", lat, 3);
    check("wr_busy_cycles", bc, 3);
    check("wr_rdata_untouched", rdata0, 0);
    check("wr_ack_cleared", ack0, 0);
    check("wr_busy_cleared", busy0, 0);
    xact(0, 1, 0, 16'h0006, 16'h5678, lat, bc, e);
    check("wr6_latency", lat, 3);
    xact(0, 0, 0, 16'h0005, 16'h0000, lat, bc, e);
    check("rd_latency", lat, 3);
    check("rd_data", rdata0, 16'h1234);
    repeat (3) @(negedge clk);
    check("rd_hold", rdata0, 16'h1234);
    @(negedge clk);
    we = 0; read_sel = 0; pc_addr = 16'h0005; alu_addr = 16'h00AA; req0 = 1;
    a1 = 0; a2 = 0; idle = 0; r1 = 0;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      if (ack0) begin
        if (a1 == 0) begin a1 = n; pc_addr = 16'h0006; end
        else if (a2 == 0) begin a2 = n; req0 = 0; end
      end else if (a1 != 0 && a2 == 0 && !busy0) idle++;
      if (a1 != 0 && n == a1 + 1) r1 = rdata0;
    end
    check("b2b_first_ack", a1, 3);
    check("b2b_second_ack", a2, 7);
    check("b2b_idle_cycles", idle, 1);
    check("b2b_first_data", r1, 16'h1234);
    check("b2b_second_data", rdata0, 16'h5678);
    xact(0, 1, 1, 16'h0007, 16'h4321, lat, bc, e);
    @(negedge clk);
    we = 1; read_sel = 1; alu_addr = 16'h0007; pc_addr = 16'h00AA; wdata = 16'hBEEF; req0 = 1;
    @(negedge clk);
    check("abort_in_wait", busy0, 1);
    reset = 1;
    #1;
    check("abort_busy_now", busy0, 0);
    check("abort_ack_now", ack0, 0);
    req0 = 0;
    @(negedge clk);
    reset = 0;
    acks = 0;
    repeat (5) begin
      @(negedge clk);
      if (ack0) acks++;
    end
    check("abort_no_ack", acks, 0);
    check("abort_rdata_cleared", rdata0, 0);
    xact(0, 0, 1, 16'h0007, 16'h0000, lat, bc, e);
    check("abort_old_value", rdata0, 16'h4321);
    xact(0, 1, 1, 16'h0105, 16'h9999, lat, bc, e);
    check("hi_wr_latency", lat, 3);
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
    check("hi_wr_err", e, 1);
    xact(0, 0, 0, 16'h0005, 16'h0000, lat, bc, e);
    check("hi_wr_dropped", rdata0, 16'h1234);
    check("inrange_err", e, 0);
    xact(0, 0, 0, 16'h0105, 16'h0000, lat, bc, e);
    check("hi_rd_err", e, 1);
    check("hi_rd_data", rdata0, 16'hFFFF);
`else
    xact(0, 0, 0, 16'h0005, 16'h0000, lat, bc, e);
    check("wrap_data", rdata0, 16'h9999);
`endif
    xact(1, 1, 0, 16'h00FF, 16'h00FF, lat, bc, e);
    check("w0_wr_latency", lat, 1);
    check("w0_wr_busy_cycles", bc, 1);
    xact(1, 0, 1, 16'h00FF, 16'h0000, lat, bc, e);
    check("w0_rd_latency", lat, 1);
    check("w0_rd_data", rdata1, 16'h00FF);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
